// File: rtl/axil_reg_pkg.sv
// Shared types and the address decoder for the AXI-Lite register slave.
// Used by axil_reg_slave (optional AXIL_REG_WR_PULSE_EN feature lives there).
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    typedef struct packed {
        logic        is_rw;
        logic        is_ro;
        logic [29:0] index;
    } dec_t;

    // Addresses below base wrap to huge offsets; the explicit guard keeps
    // them unmapped even when the wrapped index would land in range.
    function automatic dec_t decode(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned num_rw,
        input int unsigned num_ro
    );
        logic [31:0] offset;
        logic [31:0] idx;
        logic        above;
        dec_t        d;
        offset  = addr - base;
        idx     = {2'b00, offset[31:2]};
        above   = (addr >= base);
        d.index = offset[31:2];
        d.is_rw = above && (idx < num_rw);
        d.is_ro = above && (idx >= num_rw) && (idx < num_rw + num_ro);
        return d;
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bus bundle: 32-bit address/data, 4-bit strobe.
// s_axil is the slave view, m_axil the master view.
interface axil_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport s_axil (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport m_axil (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI-Lite register bank: NUM_RW control regs, NUM_RO status regs.
// Define AXIL_REG_WR_PULSE_EN to add per-register write strobes.
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int unsigned NUM_RW    = 8,
    parameter int unsigned NUM_RO    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] RW_RESET  = 32'h0000_0000
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axil_if.s_axil                s_axil,
`ifdef AXIL_REG_WR_PULSE_EN
    output logic [NUM_RW-1:0]     wr_pulse,
`endif
    output logic [NUM_RW*32-1:0]  reg_out,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] reg_in
);

    wstate_t wstate;
    rstate_t rstate;

    logic [NUM_RW-1:0][31:0] regs;

    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic        w_ok;
    logic [31:0] c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_strb;
    dec_t        wdec;
    dec_t        rdec;
    logic [31:0] rd_val;

    assign s_axil.awready = (wstate == W_IDLE) || (wstate == W_HAVE_DATA);
    assign s_axil.wready  = (wstate == W_IDLE) || (wstate == W_HAVE_ADDR);
    assign s_axil.arready = (rstate == R_IDLE);

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid && s_axil.wready;
    assign ar_hs = s_axil.arvalid && s_axil.arready;

    // Commit uses whichever half was latched earlier plus the live half.
    assign c_addr = (wstate == W_HAVE_ADDR) ? aw_addr_q : s_axil.awaddr;
    assign c_data = (wstate == W_HAVE_DATA) ? w_data_q : s_axil.wdata;
    assign c_strb = (wstate == W_HAVE_DATA) ? w_strb_q : s_axil.wstrb;

    assign wdec = decode(c_addr, BASE_ADDR, NUM_RW, NUM_RO);
    assign rdec = decode(s_axil.araddr, BASE_ADDR, NUM_RW, NUM_RO);
    assign w_ok = wdec.is_rw && !wdec.is_ro;

    assign reg_out = regs;

    always_comb begin
        commit = 1'b0;
        case (wstate)
            W_IDLE:      commit = aw_hs && w_hs;
            W_HAVE_ADDR: commit = w_hs;
            W_HAVE_DATA: commit = aw_hs;
            default:     commit = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate       <= W_IDLE;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axil.bvalid <= 1'b0;
            s_axil.bresp  <= RESP_OKAY;
        end else if (commit) begin
            wstate        <= W_RESP;
            s_axil.bvalid <= 1'b1;
            s_axil.bresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= s_axil.awaddr;
                        wstate    <= W_HAVE_ADDR;
                    end else if (w_hs) begin
                        w_data_q <= s_axil.wdata;
                        w_strb_q <= s_axil.wstrb;
                        wstate   <= W_HAVE_DATA;
                    end
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        s_axil.bvalid <= 1'b0;
                        wstate        <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_RW; i++) begin
                regs[i] <= RW_RESET;
            end
        end else if (commit && w_ok) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (wdec.index == 30'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (c_strb[b]) begin
                            regs[i][8*b +: 8] <= c_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rdec.is_rw && rdec.index == 30'(i)) begin
                rd_val = regs[i];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (rdec.is_ro && rdec.index == 30'(NUM_RW + j)) begin
                rd_val = reg_in[32*j +: 32];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate        <= R_IDLE;
            s_axil.rvalid <= 1'b0;
            s_axil.rdata  <= '0;
            s_axil.rresp  <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axil.rdata  <= rd_val;
                        s_axil.rresp  <= (rdec.is_rw || rdec.is_ro) ?
                                         RESP_OKAY : RESP_SLVERR;
                        s_axil.rvalid <= 1'b1;
                        rstate        <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        s_axil.rvalid <= 1'b0;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

`ifdef AXIL_REG_WR_PULSE_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit && w_ok) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (wdec.index == 30'(i)) begin
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule
